// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and the
// bundled stall/flush/bubble control word.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_MC_WAIT = 2'd1,
        HZ_MC_ERR  = 2'd2
    } hz_state_t;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_bubble;
        logic exmem_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_IDLE = '0;

    // Freeze everything up to EX and keep MEM fed with bubbles.
    function automatic pipe_ctrl_t ctrl_hold();
        pipe_ctrl_t c;
        c              = '0;
        c.pc_stall     = 1'b1;
        c.ifid_stall   = 1'b1;
        c.idex_stall   = 1'b1;
        c.exmem_bubble = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for hazard performance statistics.
// Only compiled when HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle execute hold and
// mispredict squash. Optional perf counters under HAZARD_PERF_CNT_EN.
//
// state      | meaning
// HZ_RUN     | normal flow; resolves mispredict, mc start, load-use
// HZ_MC_WAIT | multi-cycle op in EX, pipeline frozen until mc_done
// HZ_MC_ERR  | mc op timed out; pipeline frozen until reset
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MC_TIMEOUT     = 64,
    parameter int CNT_WIDTH      = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2,
    input  logic                      i_id_uses_rs1,
    input  logic                      i_id_uses_rs2,
    input  logic                      i_ex_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
    input  logic                      i_ex_reg_write,
    input  logic                      i_ex_is_load,
    input  logic                      i_ex_is_mc,
    input  logic                      i_ex_mispredict,
    input  logic                      i_mc_done,
    output logic                      o_pc_stall,
    output logic                      o_ifid_stall,
    output logic                      o_ifid_flush,
    output logic                      o_idex_stall,
    output logic                      o_idex_bubble,
    output logic                      o_exmem_bubble,
    output logic                      o_mc_start,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]               o_perf_load_stalls,
    output logic [31:0]               o_perf_mc_cycles,
    output logic [31:0]               o_perf_flushes,
`endif
    output logic                      o_mc_timeout
);

    hz_state_t            r_state;
    logic [CNT_WIDTH-1:0] r_wait_cnt;
    logic                 r_mc_timeout;

    hz_state_t            w_state_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_timeout_nxt;
    pipe_ctrl_t           w_ctrl;
    logic                 w_mc_start;
    logic                 w_load_use;
    logic                 w_squash;
    logic                 w_mc_issue;

    assign w_load_use = i_ex_valid & i_ex_is_load & i_ex_reg_write
                      & (i_ex_rd != REG_ADDR_WIDTH'(REG_ZERO)) & i_id_valid
                      & ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd))
                       | (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));

    assign w_squash   = i_ex_valid & i_ex_mispredict;
    assign w_mc_issue = i_ex_valid & i_ex_is_mc;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_wait_cnt;
        w_timeout_nxt = r_mc_timeout;
        w_ctrl        = CTRL_IDLE;
        w_mc_start    = 1'b0;

        case (r_state)
            HZ_RUN: begin
                if (w_squash) begin
                    w_ctrl.ifid_flush  = 1'b1;
                    w_ctrl.idex_bubble = 1'b1;
                end else if (w_mc_issue) begin
                    w_ctrl      = ctrl_hold();
                    w_mc_start  = 1'b1;
                    w_state_nxt = HZ_MC_WAIT;
                    w_cnt_nxt   = CNT_WIDTH'(1);
                end else if (w_load_use) begin
                    // One bubble suffices: the load reaches MEM next cycle.
                    w_ctrl.pc_stall    = 1'b1;
                    w_ctrl.ifid_stall  = 1'b1;
                    w_ctrl.idex_bubble = 1'b1;
                end
            end

            HZ_MC_WAIT: begin
                if (i_mc_done) begin
                    w_state_nxt = HZ_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_ctrl = ctrl_hold();
                    if (r_wait_cnt == CNT_WIDTH'(MC_TIMEOUT)) begin
                        w_state_nxt   = HZ_MC_ERR;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_wait_cnt + 1'b1;
                    end
                end
            end

            HZ_MC_ERR: begin
                w_ctrl = ctrl_hold();
            end

            default: begin
                w_state_nxt = HZ_RUN;
                w_cnt_nxt   = '0;
            end
        endcase

        if (reset) begin
            w_ctrl     = CTRL_IDLE;
            w_mc_start = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= HZ_RUN;
            r_wait_cnt   <= '0;
            r_mc_timeout <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_cnt_nxt;
            r_mc_timeout <= w_timeout_nxt;
        end
    end

    assign o_pc_stall     = w_ctrl.pc_stall;
    assign o_ifid_stall   = w_ctrl.ifid_stall;
    assign o_ifid_flush   = w_ctrl.ifid_flush;
    assign o_idex_stall   = w_ctrl.idex_stall;
    assign o_idex_bubble  = w_ctrl.idex_bubble;
    assign o_exmem_bubble = w_ctrl.exmem_bubble;
    assign o_mc_start     = w_mc_start;
    assign o_mc_timeout   = r_mc_timeout & ~reset;

`ifdef HAZARD_PERF_CNT_EN
    logic w_ev_load;
    logic w_ev_flush;
    logic w_ev_mc;

    assign w_ev_load  = (r_state == HZ_RUN) & ~w_squash & ~w_mc_issue & w_load_use;
    assign w_ev_flush = (r_state == HZ_RUN) & w_squash;
    assign w_ev_mc    = (r_state == HZ_MC_WAIT);

    hazard_perf_cnt #(.WIDTH(32)) u_cnt_load (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_ev_load),
        .o_count (o_perf_load_stalls)
    );

    hazard_perf_cnt #(.WIDTH(32)) u_cnt_mc (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_ev_mc),
        .o_count (o_perf_mc_cycles)
    );

    hazard_perf_cnt #(.WIDTH(32)) u_cnt_flush (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_ev_flush),
        .o_count (o_perf_flushes)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MC_TIMEOUT=8); perf counters are
// also checked when HAZARD_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int RW = 5;

    // Output vector: {pc_stall, ifid_stall, ifid_flush, idex_stall,
    //                 idex_bubble, exmem_bubble, mc_start, mc_timeout}
    localparam logic [7:0] O_ZERO = 8'b0000_0000;
    localparam logic [7:0] O_LU   = 8'b1100_1000;
    localparam logic [7:0] O_MCS  = 8'b1101_0110;
    localparam logic [7:0] O_HOLD = 8'b1101_0100;
    localparam logic [7:0] O_FL   = 8'b0010_1000;
    localparam logic [7:0] O_ERR  = 8'b1101_0101;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid, id_uses_rs1, id_uses_rs2;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          ex_valid, ex_reg_write, ex_is_load, ex_is_mc, ex_mispredict, mc_done;
    logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble;
    logic          exmem_bubble, mc_start, mc_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   perf_load, perf_mc, perf_fl;
`endif
    logic [7:0]    obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign obs = {pc_stall, ifid_stall, ifid_flush, idex_stall,
                  idex_bubble, exmem_bubble, mc_start, mc_timeout};

    pipe_hazard_ctrl #(.REG_ADDR_WIDTH(RW), .MC_TIMEOUT(8), .CNT_WIDTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_id_valid        (id_valid),
        .i_id_rs1          (id_rs1),
        .i_id_rs2          (id_rs2),
        .i_id_uses_rs1     (id_uses_rs1),
        .i_id_uses_rs2     (id_uses_rs2),
        .i_ex_valid        (ex_valid),
        .i_ex_rd           (ex_rd),
        .i_ex_reg_write    (ex_reg_write),
        .i_ex_is_load      (ex_is_load),
        .i_ex_is_mc        (ex_is_mc),
        .i_ex_mispredict   (ex_mispredict),
        .i_mc_done         (mc_done),
        .o_pc_stall        (pc_stall),
        .o_ifid_stall      (ifid_stall),
        .o_ifid_flush      (ifid_flush),
        .o_idex_stall      (idex_stall),
        .o_idex_bubble     (idex_bubble),
        .o_exmem_bubble    (exmem_bubble),
        .o_mc_start        (mc_start),
`ifdef HAZARD_PERF_CNT_EN
        .o_perf_load_stalls(perf_load),
        .o_perf_mc_cycles  (perf_mc),
        .o_perf_flushes    (perf_fl),
`endif
        .o_mc_timeout      (mc_timeout)
    );

    task automatic idle();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_rd = 0; ex_reg_write = 0; ex_is_load = 0; ex_is_mc = 0;
        ex_mispredict = 0; mc_done = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [RW-1:0] rd);
        ex_valid = 1; ex_is_load = 1; ex_reg_write = 1; ex_rd = rd;
        id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5'd3; id_uses_rs2 = 1; id_rs2 = rd;
    endtask

    task automatic apply_reset();
        reset = 1; idle();
        next_cycle(); next_cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        ex_valid = 1; ex_is_mc = 1;
        @(negedge clk);
        checks++;
        if (obs !== O_ZERO) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", obs, O_ZERO);
        end
        next_cycle(); next_cycle();
        idle(); reset = 0;
        @(negedge clk);
        checks++;
        if (obs !== O_ZERO) begin
            errors++; $display("FAIL post_reset_idle: got %b expected %b", obs, O_ZERO);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        set_load_use(5'd5);
        @(negedge clk);
        checks++;
        if (obs !== O_LU) begin
            errors++; $display("FAIL lu_stall: got %b expected %b", obs, O_LU);
        end
        next_cycle();
        ex_valid = 0; ex_is_load = 0; ex_reg_write = 0;
        @(negedge clk);
        checks++;
        if (obs !== O_ZERO) begin
            errors++; $display("FAIL lu_release: got %b expected %b", obs, O_ZERO);
        end
        next_cycle();
        set_load_use(5'd0);
        @(negedge clk);
        checks++;
        if (obs !== O_ZERO) begin
            errors++; $display("FAIL lu_x0: got %b expected %b", obs, O_ZERO);
        end
        next_cycle();
        // rs1 matches but is not read: no hazard; then read it: hazard.
        set_load_use(5'd7); id_rs2 = 5'd9; id_rs1 = 5'd7; id_uses_rs1 = 0;
        @(negedge clk);
        checks++;
        if (obs !== O_ZERO) begin
            errors++; $display("FAIL lu_rs1_unused: got %b expected %b", obs, O_ZERO);
        end
        id_uses_rs1 = 1;
        @(negedge clk);
        checks++;
        if (obs !== O_LU) begin
            errors++; $display("FAIL lu_rs1: got %b expected %b", obs, O_LU);
        end
        ex_reg_write = 0;
        @(negedge clk);
        checks++;
        if (obs !== O_ZERO) begin
            errors++; $display("FAIL lu_no_write: got %b expected %b", obs, O_ZERO);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_mc_op();
        ex_valid = 1; ex_is_mc = 1;
        @(negedge clk);
        checks++;
        if (obs !== O_MCS) begin
            errors++; $display("FAIL mc_start_cycle: got %b expected %b", obs, O_MCS);
        end
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            ex_mispredict = (i == 2);
            set_load_use(5'd4); ex_is_mc = 1; ex_is_load = (i == 3);
            @(negedge clk);
            checks++;
            if (obs !== O_HOLD) begin
                errors++; $display("FAIL mc_wait[%0d]: got %b expected %b", i, obs, O_HOLD);
            end
        end
        next_cycle();
        idle(); ex_valid = 1; ex_is_mc = 1; mc_done = 1;
        @(negedge clk);
        checks++;
        if (obs !== O_ZERO) begin
            errors++; $display("FAIL mc_done_cycle: got %b expected %b", obs, O_ZERO);
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (obs !== O_ZERO) begin
            errors++; $display("FAIL mc_back_to_run: got %b expected %b", obs, O_ZERO);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        // Fastest op: done on the cycle right after start, then a new op.
        for (int k = 0; k < 2; k++) begin
            ex_valid = 1; ex_is_mc = 1; mc_done = 0;
            @(negedge clk);
            checks++;
            if (obs !== O_MCS) begin
                errors++; $display("FAIL b2b_start[%0d]: got %b expected %b", k, obs, O_MCS);
            end
            next_cycle();
            mc_done = 1;
            @(negedge clk);
            checks++;
            if (obs !== O_ZERO) begin
                errors++; $display("FAIL b2b_done[%0d]: got %b expected %b", k, obs, O_ZERO);
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_mispredict();
        set_load_use(5'd6); ex_mispredict = 1;
        @(negedge clk);
        checks++;
        if (obs !== O_FL) begin
            errors++; $display("FAIL flush_over_lu: got %b expected %b", obs, O_FL);
        end
        next_cycle();
        idle(); ex_valid = 1; ex_is_mc = 1; ex_mispredict = 1;
        @(negedge clk);
        checks++;
        if (obs !== O_FL) begin
            errors++; $display("FAIL flush_over_mc: got %b expected %b", obs, O_FL);
        end
        next_cycle();
        idle(); ex_mispredict = 1;
        @(negedge clk);
        checks++;
        if (obs !== O_ZERO) begin
            errors++; $display("FAIL flush_invalid_ex: got %b expected %b", obs, O_ZERO);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_done_at_timeout();
        ex_valid = 1; ex_is_mc = 1;
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            mc_done = (i == 8);
        end
        @(negedge clk);
        checks++;
        if (obs !== O_ZERO) begin
            errors++; $display("FAIL done_at_limit: got %b expected %b", obs, O_ZERO);
        end
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (obs !== O_ZERO) begin
            errors++; $display("FAIL no_timeout_after_done: got %b expected %b", obs, O_ZERO);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        ex_valid = 1; ex_is_mc = 1;
        for (int i = 1; i <= 8; i++) next_cycle();
        @(negedge clk);
        checks++;
        if (obs !== O_HOLD) begin
            errors++; $display("FAIL to_last_wait: got %b expected %b", obs, O_HOLD);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (obs !== O_ERR) begin
            errors++; $display("FAIL to_err_entry: got %b expected %b", obs, O_ERR);
        end
        next_cycle();
        mc_done = 1;
        @(negedge clk);
        next_cycle();
        mc_done = 0;
        @(negedge clk);
        checks++;
        if (obs !== O_ERR) begin
            errors++; $display("FAIL to_done_ignored: got %b expected %b", obs, O_ERR);
        end
        reset = 1;
        @(negedge clk);
        checks++;
        if (obs !== O_ZERO) begin
            errors++; $display("FAIL to_reset_cycle: got %b expected %b", obs, O_ZERO);
        end
        next_cycle();
        reset = 0; idle();
        @(negedge clk);
        checks++;
        if (obs !== O_ZERO) begin
            errors++; $display("FAIL to_cleared: got %b expected %b", obs, O_ZERO);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        ex_valid = 1; ex_is_mc = 1;
        next_cycle(); next_cycle();
        reset = 1;
        @(negedge clk);
        checks++;
        if (obs !== O_ZERO) begin
            errors++; $display("FAIL rmw_reset_cycle: got %b expected %b", obs, O_ZERO);
        end
        next_cycle();
        reset = 0; idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== O_ZERO) begin
                errors++; $display("FAIL rmw_after[%0d]: got %b expected %b", i, obs, O_ZERO);
            end
            next_cycle();
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({perf_load, perf_mc, perf_fl} !== 96'd0) begin
            errors++; $display("FAIL perf_reset: got %0d/%0d/%0d expected 0/0/0",
                               perf_load, perf_mc, perf_fl);
        end
        next_cycle();
        set_load_use(5'd8); ex_mispredict = 1;
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if ({perf_load, perf_fl} !== {32'd0, 32'd1}) begin
            errors++; $display("FAIL perf_flush_no_lu: got %0d/%0d expected 0/1",
                               perf_load, perf_fl);
        end
        for (int i = 0; i < 3; i++) begin
            set_load_use(5'd10 + 5'(i));
            next_cycle();
            idle();
            next_cycle();
        end
        ex_valid = 1; ex_is_mc = 1;
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
            mc_done = (i == 5);
        end
        next_cycle();
        idle(); ex_valid = 1; ex_mispredict = 1;
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if ({perf_load, perf_mc, perf_fl} !== {32'd3, 32'd5, 32'd2}) begin
            errors++; $display("FAIL perf_totals: got %0d/%0d/%0d expected 3/5/2",
                               perf_load, perf_mc, perf_fl);
        end
        next_cycle();
    endtask
`endif

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_mc_op();
        test_back_to_back();
        test_mispredict();
        test_done_at_timeout();
        test_timeout();
        test_reset_mid_wait();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
